// File: rtl/drive_direct_uart_tx.sv
// Drive Direct (opcode 0x91) packet sender over 8N1 UART; input change to tx start bit is 2 cycles from the cur register update.
// No backpressure: changes seen while a packet is in flight are coalesced into a single follow-up packet carrying the latest value.
module drive_direct_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SPEED_STEP   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] bin_speed_wheel1,
  input  logic [2:0] bin_speed_wheel2,
  output logic       tx,
  output logic       busy,
  output logic       packet_sent
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]        OPCODE    = 8'h91;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [2:0]        byte_idx, byte_n;
  logic [4:0][7:0]   pkt, pkt_n;
  logic [2:0]        cur1, cur2;
  logic [2:0]        snap1, snap1_n;
  logic [2:0]        snap2, snap2_n;
  logic              pending, pending_n;
  logic              sent_n;
  logic              baud_done;
  logic [7:0]        cur_byte;
  logic [15:0]       vel1, vel2;

  // Level 0 yields 0 for either sign, since two's complement negation of zero is zero.
  function automatic logic [15:0] wheel_vel(input logic [2:0] code);
    logic [15:0] mag;
    mag = {14'd0, code[1:0]} * 16'(SPEED_STEP);
    return code[2] ? (~mag + 16'd1) : mag;
  endfunction

  assign vel1      = wheel_vel(cur1);
  assign vel2      = wheel_vel(cur2);
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    cur1 <= bin_speed_wheel1;
    cur2 <= bin_speed_wheel2;
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      pkt         <= '0;
      snap1       <= '0;
      snap2       <= '0;
      pending     <= 1'b1;
      packet_sent <= 1'b0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_n;
      bit_idx     <= bit_n;
      byte_idx    <= byte_n;
      pkt         <= pkt_n;
      snap1       <= snap1_n;
      snap2       <= snap2_n;
      pending     <= pending_n;
      packet_sent <= sent_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    pkt_n     = pkt;
    snap1_n   = snap1;
    snap2_n   = snap2;
    pending_n = pending;
    sent_n    = 1'b0;
    case (state)
      IDLE: begin
        if (pending || ({cur1, cur2} != {snap1, snap2})) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        snap1_n   = cur1;
        snap2_n   = cur2;
        pkt_n     = {vel2[7:0], vel2[15:8], vel1[7:0], vel1[15:8], OPCODE};
        pending_n = 1'b0;
        byte_n    = '0;
        bit_n     = '0;
        baud_n    = '0;
        state_n   = START;
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (byte_idx == 3'd4) begin
            sent_n  = 1'b1;
            state_n = IDLE;
          end else begin
            byte_n  = byte_idx + 3'd1;
            state_n = START;
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cur_byte = pkt[0];
    case (byte_idx)
      3'd1:    cur_byte = pkt[1];
      3'd2:    cur_byte = pkt[2];
      3'd3:    cur_byte = pkt[3];
      3'd4:    cur_byte = pkt[4];
      default: cur_byte = pkt[0];
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = (state != IDLE);
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_drive_direct_uart_tx.sv
// Self-checking bench for drive_direct_uart_tx: table vectors, corner sequences, and randomized traffic against a packet-level model.
module tb_drive_direct_uart_tx;

  localparam int CPB  = 4;
  localparam int STEP = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] w1  = 3'b000;
  logic [2:0] w2  = 3'b000;
  logic       tx, busy, packet_sent;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [2:0] m_snap1, m_snap2;

  typedef struct {
    logic [2:0]  w1;
    logic [2:0]  w2;
    logic [31:0] vels;
  } vec_t;
  vec_t tbl[8];

  drive_direct_uart_tx #(.CLKS_PER_BIT(CPB), .SPEED_STEP(STEP)) dut (
    .clk              (clk),
    .rst              (rst),
    .bin_speed_wheel1 (w1),
    .bin_speed_wheel2 (w2),
    .tx               (tx),
    .busy             (busy),
    .packet_sent      (packet_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_vel(input logic [2:0] c);
    int m;
    m = int'(c[1:0]) * STEP;
    if (c[2]) m = -m;
    return m[15:0];
  endfunction

  task automatic push_bytes(input logic [31:0] vels);
    exp_q.push_back(8'h91);
    exp_q.push_back(vels[31:24]);
    exp_q.push_back(vels[23:16]);
    exp_q.push_back(vels[15:8]);
    exp_q.push_back(vels[7:0]);
  endtask

  task automatic push_pkt(input logic [2:0] c1, input logic [2:0] c2);
    push_bytes({ref_vel(c1), ref_vel(c2)});
    m_snap1 = c1;
    m_snap2 = c2;
  endtask

  // UART receiver: samples every cycle, checks each bit is steady for its full width.
  int         m_in = 0, m_cyc = 0, m_bit = 0, m_bad = 0;
  logic [7:0] m_sh = '0;
  always @(negedge clk) begin
    if (busy === 1'b1 && packet_sent === 1'b1) begin
      errors++;
      $display("FAIL busy_sent_excl: got both high expected at most one at %0t", $time);
    end
    if (rst) begin
      m_in = 0;
    end else begin
      if (m_in == 0 && tx === 1'b0) begin
        m_in  = 1;
        m_cyc = 0;
        m_bad = 0;
      end
      if (m_in != 0) begin
        m_bit = m_cyc / CPB;
        if (m_bit == 0) begin
          if (tx !== 1'b0) m_bad = 1;
        end else if (m_bit <= 8) begin
          if (m_cyc % CPB == 0) m_sh[m_bit-1] = tx;
          else if (tx !== m_sh[m_bit-1]) m_bad = 1;
        end else if (tx !== 1'b1) begin
          m_bad = 1;
        end
        m_cyc++;
        if (m_cyc == 10 * CPB) begin
          m_in = 0;
          rx_q.push_back(m_sh);
          check("uart_frame_shape", m_bad, 0);
        end
      end
    end
  end

  task automatic wait_sent(input int budget, output int n);
    n = 0;
    while (packet_sent !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0, n = 0;
    while (q < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0 && tx === 1'b1) q++;
      else q = 0;
    end
    check({tag, "_quiet"}, (q >= 3), 1);
  endtask

  task automatic compare_packets(input string tag);
    int n;
    repeat (2) @(negedge clk);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Entered one negedge before the edge that moves the DUT into LOAD.
  task automatic run_packet(input string tag);
    int n;
    @(negedge clk);
    check({tag, "_load_busy"}, busy, 1);
    check({tag, "_load_tx"}, tx, 1);
    @(negedge clk);
    check({tag, "_start_tx"}, tx, 0);
    wait_sent(400, n);
    check({tag, "_frame_len"}, n, 50 * CPB);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_tx"}, tx, 1);
  endtask

  task automatic send_codes(input string tag, input logic [2:0] c1, input logic [2:0] c2);
    w1 = c1;
    w2 = c2;
    @(negedge clk);
    check({tag, "_cur_tx"}, tx, 1);
    check({tag, "_cur_busy"}, busy, 0);
    run_packet(tag);
  endtask

  task automatic no_activity(input string tag, input int cycles);
    int act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || packet_sent !== 1'b0) act++;
    end
    check({tag, "_no_activity"}, act, 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{3'b011, 3'b001, 32'h012C_0064};
    tbl[1] = '{3'b111, 3'b100, 32'hFED4_0000};
    tbl[2] = '{3'b101, 3'b010, 32'hFF9C_00C8};
    tbl[3] = '{3'b110, 3'b011, 32'hFF38_012C};
    tbl[4] = '{3'b001, 3'b111, 32'h0064_FED4};
    tbl[5] = '{3'b100, 3'b000, 32'h0000_0000};
    tbl[6] = '{3'b000, 3'b100, 32'h0000_0000};
    tbl[7] = '{3'b010, 3'b110, 32'h00C8_FF38};

    // Reset with both codes zero, then the post-reset packet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_sent", packet_sent, 0);
    push_pkt(3'b000, 3'b000);
    rst = 1'b0;
    run_packet("post_rst");
    compare_packets("post_rst");
    no_activity("post_rst", 20);

    for (int i = 0; i < 8; i++) begin
      push_bytes(tbl[i].vels);
      m_snap1 = tbl[i].w1;
      m_snap2 = tbl[i].w2;
      send_codes($sformatf("vec%0d", i), tbl[i].w1, tbl[i].w2);
      compare_packets($sformatf("vec%0d", i));
    end

    // Coalescing: two changes in flight give one follow-up with the latest value.
    push_pkt(3'b001, 3'b010);
    w1 = 3'b001;
    w2 = 3'b010;
    repeat (3) @(negedge clk);
    check("coal_start_tx", tx, 0);
    repeat (30) @(negedge clk);
    w1 = 3'b010;
    repeat (30) @(negedge clk);
    w1 = 3'b011;
    push_pkt(3'b011, 3'b010);
    wait_sent(400, n);
    check("coal_first_sent", packet_sent, 1);
    @(negedge clk);
    check("coal_load_busy", busy, 1);
    check("coal_load_tx", tx, 1);
    @(negedge clk);
    check("coal_restart_tx", tx, 0);
    wait_sent(400, n);
    check("coal_second_sent", packet_sent, 1);
    no_activity("coal", 300);
    compare_packets("coal");

    // Constant inputs: no traffic.
    no_activity("hold", 1000);

    // wheel2 leaves its snapshot and returns inside one packet: no follow-up.
    push_pkt(3'b101, 3'b010);
    w1 = 3'b101;
    repeat (23) @(negedge clk);
    w2 = 3'b000;
    repeat (30) @(negedge clk);
    w2 = 3'b010;
    wait_sent(400, n);
    check("revert_sent", packet_sent, 1);
    no_activity("revert", 300);
    compare_packets("revert");

    // Reset in the middle of byte 2 abandons the packet; a fresh one follows.
    w2 = 3'b111;
    repeat (3) @(negedge clk);
    check("midrst_start_tx", tx, 0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_sent", packet_sent, 0);
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_pkt(3'b101, 3'b111);
    run_packet("midrst");
    compare_packets("midrst");

    // Randomized traffic against the packet-level model.
    for (int t = 0; t < 20; t++) begin
      logic [2:0] c1, c2;
      int k;
      c1 = 3'($urandom_range(0, 7));
      c2 = 3'($urandom_range(0, 7));
      if ({c1, c2} != {m_snap1, m_snap2}) begin
        push_pkt(c1, c2);
        w1 = c1;
        w2 = c2;
        n  = 0;
        while (tx !== 1'b0 && n < 10) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("rnd%0d_latency", t), n, 3);
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
          repeat ($urandom_range(1, 40)) @(negedge clk);
          w1 = 3'($urandom_range(0, 7));
          w2 = 3'($urandom_range(0, 7));
        end
        if ({w1, w2} != {m_snap1, m_snap2}) push_pkt(w1, w2);
      end else begin
        w1 = c1;
        w2 = c2;
        repeat (5) @(negedge clk);
      end
      wait_quiet($sformatf("rnd%0d", t));
      compare_packets($sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/drive_direct_uart_tx.md
Name: drive_direct_uart_tx

Overview:
- Downstream of the motion command stage. Consumes the two 3-bit wheel speed codes and turns them into iRobot Create "Drive Direct" packets (opcode 145, 5 bytes).
- Sends each packet on a single UART TX line (8N1).
- A packet is sent once after reset, then whenever either wheel code changes. Changes that arrive while a packet is in flight are coalesced.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- SPEED_STEP, 100, velocity per magnitude level in mm/s. Must be ≤ 166, so that 3*SPEED_STEP ≤ 500.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bin_speed_wheel1  input  3  right wheel code: bit2 = reverse, bits1:0 = magnitude level 0..3.
- bin_speed_wheel2  input  3  left wheel code, same encoding.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high while a packet is being transmitted.
- packet_sent  output  1  one-cycle pulse when a packet's final stop bit completes.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; it acts on the clk edge where rst=1.
  - Reset values: tx=1, busy=0, packet_sent=0, FSM=IDLE, bit/byte/baud counters=0, snapshot registers=0.
  - A pending-send flag is set by reset, so one packet goes out after reset.
- Input handling:
  - Both wheel codes are registered every cycle into cur1/cur2.
  - A change is detected when {cur1,cur2} differs from {snap1,snap2}.
  - Change detection is active only in IDLE.
- Velocity mapping (per wheel, 16-bit two's complement):
  - mag = code[1:0] * SPEED_STEP, truncated to 16 bits.
  - vel = code[2] ? -mag : mag.
  - Level 0 gives 0x0000 regardless of the reverse bit, so there is no negative zero.
- Packet format, in order:
  - 0x91
  - vel1[15:8], vel1[7:0] (right wheel)
  - vel2[15:8], vel2[7:0] (left wheel)
- UART framing:
  - Each byte is sent as start bit (0), 8 data bits LSB first, stop bit (1).
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - There is no idle gap between bytes: the next start bit immediately follows the previous stop bit.
  - A packet occupies 50*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx=1, busy=0. If the pending flag is set or a change is detected, go to LOAD.
  - LOAD (1 cycle): snap1/snap2 <= cur1/cur2; compute and latch all 5 bytes; clear the pending flag; byte_idx=0; busy=1. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: tx = byte[bit_idx] for CLKS_PER_BIT cycles each, bit_idx 0..7. Go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<4: byte_idx+1, go to START;
    - otherwise: go to IDLE, with packet_sent=1 and busy=0 in that same first IDLE cycle.
- Latency: if an input changes before clk edge N, then cur is updated at N, LOAD is taken at N+1, and tx falls at edge N+2.
- Coalescing:
  - Input changes during LOAD through STOP do not affect the bytes in flight.
  - On return to IDLE, the current value is compared to the snapshot. A changed value starts the next LOAD on the cycle after packet_sent.
  - Several changes during one packet produce exactly one follow-up packet, carrying the latest value.
  - A change that reverts to the snapshot value before the packet ends produces no follow-up packet.
- Reset mid-packet:
  - tx=1 and busy=0 from the reset edge; the partial byte is abandoned.
  - A fresh full packet with the current inputs starts 2 cycles after rst deasserts.
- busy and packet_sent are never both 1 in the same cycle.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and SPEED_STEP=100.
1. Hold rst 3 cycles with both codes 000, then release → one packet 91 00 00 00 00; packet_sent pulses after 200 cycles of busy; tx stays high afterwards.
2. From idle, set wheel1=011 and wheel2=001 → tx falls 2 cycles later; packet 91 01 2C 00 64; each bit exactly 4 cycles wide.
3. Set wheel1=111 and wheel2=100 → packet 91 FE D4 00 00.
4. During a packet, change wheel1 to 010, then to 011 → the in-flight packet is unchanged; exactly one more packet follows, 91 01 2C xx xx; LOAD starts the cycle after packet_sent.
5. Assert rst mid-way through byte 2 → tx=1 and busy=0 on the next edge; after release, a new full packet with the current codes is sent; no partial bytes resume.
6. Hold the inputs constant for 1000 cycles after a packet → no packet, tx=1, busy=0. Also toggle wheel2 away from its snapshot and back within one packet → no follow-up packet.
